// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART receive frame sequencer.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    LEN,
    PAYLOAD,
    CSUM,
    DELIVER
  } frame_state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] DEFAULT_SOF = 8'hA5;

endpackage

// File: rtl/frame_timeout_cnt.sv
// Inter-byte idle timer: counts run cycles, clear has priority, expire flags
// the cycle in which the count would reach TIMEOUT_CYC-1.
module frame_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int unsigned CW    = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned LIMIT = (TIMEOUT_CYC > 1) ? TIMEOUT_CYC - 2 : 0;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = run & ~clear & (cnt == CW'(LIMIT));

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame sequencer: pops SOF/CMD/LEN/payload/XOR-checksum frames from a
// show-ahead FIFO, writes payload out, and hands checked frames to the consumer.
module uart_rx_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter logic [7:0]  SOF_BYTE    = DEFAULT_SOF,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned AW          = $clog2(MAX_LEN)
) (
  input  logic          ckht,
  input  logic          rst,
  input  logic          en,
  input  logic          rx_empty,
  input  logic [7:0]    rx_data,
  output logic          rx_rd,
  output logic          pl_we,
  output logic [AW-1:0] pl_addr,
  output logic [7:0]    pl_data,
  output logic          frame_valid,
  input  logic          frame_ready,
  output logic [7:0]    frame_cmd,
  output logic [7:0]    frame_len,
  output logic          frame_err,
  output logic [1:0]    err_code,
  output logic [7:0]    drop_cnt
);

  frame_state_t state, state_nx;

  logic [7:0]    csum, csum_nx;
  logic [7:0]    idx, idx_nx;
  logic [7:0]    cmd_nx, len_nx, drop_nx, data_nx;
  logic [AW-1:0] addr_nx;
  logic          we_nx, err_nx;
  logic [1:0]    code_nx;
  logic          pop, in_frame, tmr_clear, tmr_run, expire;

  // Pops are also blocked while rst is held so the FIFO never loses a byte
  // that the reset FSM cannot see.
  assign pop         = en & ~rx_empty & (state != DELIVER) & ~rst;
  assign rx_rd       = pop;
  assign frame_valid = (state == DELIVER);

  assign in_frame  = (state == CMD) || (state == LEN) ||
                     (state == PAYLOAD) || (state == CSUM);
  assign tmr_clear = pop | ~in_frame;
  assign tmr_run   = en & ~pop & in_frame;

  frame_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk   (ckht),
    .rst   (rst),
    .clear (tmr_clear),
    .run   (tmr_run),
    .expire(expire)
  );

  always_ff @(posedge ckht or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    csum_nx  = csum;
    idx_nx   = idx;
    cmd_nx   = frame_cmd;
    len_nx   = frame_len;
    drop_nx  = drop_cnt;
    we_nx    = 1'b0;
    addr_nx  = pl_addr;
    data_nx  = pl_data;
    err_nx   = 1'b0;
    code_nx  = err_code;

    unique case (state)
      IDLE: begin
        if (pop) begin
          if (rx_data == SOF_BYTE) begin
            state_nx = CMD;
          end else if (drop_cnt != 8'hFF) begin
            drop_nx = drop_cnt + 8'd1;
          end
        end
      end
      CMD: begin
        if (pop) begin
          cmd_nx   = rx_data;
          csum_nx  = rx_data;
          state_nx = LEN;
        end
      end
      LEN: begin
        if (pop) begin
          len_nx  = rx_data;
          csum_nx = csum ^ rx_data;
          if (rx_data > 8'(MAX_LEN)) begin
            err_nx   = 1'b1;
            code_nx  = ERR_LEN;
            state_nx = IDLE;
          end else if (rx_data == 8'd0) begin
            state_nx = CSUM;
          end else begin
            idx_nx   = 8'd0;
            state_nx = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (pop) begin
          csum_nx = csum ^ rx_data;
          idx_nx  = idx + 8'd1;
          we_nx   = 1'b1;
          addr_nx = idx[AW-1:0];
          data_nx = rx_data;
          if (idx == frame_len - 8'd1) begin
            state_nx = CSUM;
          end
        end
      end
      CSUM: begin
        if (pop) begin
          if (rx_data == csum) begin
            state_nx = DELIVER;
          end else begin
            err_nx   = 1'b1;
            code_nx  = ERR_CSUM;
            state_nx = IDLE;
          end
        end
      end
      DELIVER: begin
        if (frame_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // expire only fires on a no-pop cycle inside a frame, so it never races a byte
    if (expire) begin
      err_nx   = 1'b1;
      code_nx  = ERR_TIMEOUT;
      state_nx = IDLE;
    end
  end

  always_ff @(posedge ckht or posedge rst) begin
    if (rst) begin
      csum      <= '0;
      idx       <= '0;
      frame_cmd <= '0;
      frame_len <= '0;
      drop_cnt  <= '0;
      pl_we     <= 1'b0;
      pl_addr   <= '0;
      pl_data   <= '0;
      frame_err <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      csum      <= csum_nx;
      idx       <= idx_nx;
      frame_cmd <= cmd_nx;
      frame_len <= len_nx;
      drop_cnt  <= drop_nx;
      pl_we     <= we_nx;
      pl_addr   <= addr_nx;
      pl_data   <= data_nx;
      frame_err <= err_nx;
      err_code  <= code_nx;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl with a show-ahead FIFO model.
module tb_uart_rx_frame_ctrl;

  localparam int unsigned AW = 4;

  logic          ckht = 1'b0;
  logic          rst, en, rx_empty, rx_rd, pl_we, frame_valid, frame_ready, frame_err;
  logic [7:0]    rx_data, pl_data, frame_cmd, frame_len, drop_cnt;
  logic [AW-1:0] pl_addr;
  logic [1:0]    err_code;

  always #5 ckht = ~ckht;

  uart_rx_frame_ctrl #(
    .SOF_BYTE   (8'hA5),
    .MAX_LEN    (16),
    .TIMEOUT_CYC(8)
  ) dut (
    .ckht       (ckht),
    .rst        (rst),
    .en         (en),
    .rx_empty   (rx_empty),
    .rx_data    (rx_data),
    .rx_rd      (rx_rd),
    .pl_we      (pl_we),
    .pl_addr    (pl_addr),
    .pl_data    (pl_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_cmd  (frame_cmd),
    .frame_len  (frame_len),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .drop_cnt   (drop_cnt)
  );

  // show-ahead FIFO model
  logic [7:0] mem [0:255];
  logic [7:0] rd_ptr = 8'd0;
  logic [7:0] wr_ptr = 8'd0;
  assign rx_empty = (rd_ptr == wr_ptr);
  assign rx_data  = mem[rd_ptr];
  always @(posedge ckht) if (rx_rd) rd_ptr <= rd_ptr + 8'd1;

  // event log sampled mid-cycle
  int pop_cnt = 0, wr_n = 0, err_cnt = 0, valid_cnt = 0, both_cnt = 0;
  logic [7:0] wr_addr [0:63];
  logic [7:0] wr_data [0:63];
  always @(negedge ckht) begin
    if (rx_rd) pop_cnt <= pop_cnt + 1;
    if (pl_we) begin
      wr_addr[wr_n] <= 8'(pl_addr);
      wr_data[wr_n] <= pl_data;
      wr_n <= wr_n + 1;
    end
    if (frame_err) err_cnt <= err_cnt + 1;
    if (frame_valid) valid_cnt <= valid_cnt + 1;
    if (frame_err && frame_valid) both_cnt <= both_cnt + 1;
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ckht);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic wait_valid(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      if (frame_valid) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic wait_err(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      if (frame_err) ok = 1'b1;
      else tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, flag;
    int w0, e0, v0, p0;

    rst = 1'b1; en = 1'b0; frame_ready = 1'b1;
    #2;
    check("rst_ctrl", {rx_rd, pl_we, frame_valid, frame_err, err_code}, 0);
    check("rst_data", {pl_addr, pl_data, frame_cmd}, 0);
    check("rst_len_drop", {frame_len, drop_cnt}, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // nominal frame: A5 01 02 11 22 30
    push(8'hA5); push(8'h01); push(8'h02); push(8'h11); push(8'h22); push(8'h30);
    en = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      check("nom_pop", rx_rd, 1);
      if (i == 4) check("nom_wr0", {pl_we, pl_addr, pl_data}, {1'b1, 4'd0, 8'h11});
      if (i == 5) check("nom_wr1", {pl_we, pl_addr, pl_data}, {1'b1, 4'd1, 8'h22});
      tick();
    end
    check("nom_valid", frame_valid, 1);
    check("nom_cmd", frame_cmd, 8'h01);
    check("nom_len", frame_len, 8'h02);
    check("nom_noerr", frame_err, 0);
    check("nom_nopop", rx_rd, 0);
    tick();
    check("nom_valid_drop", {frame_valid, pl_we}, 0);

    // noise then zero-length frame
    w0 = wr_n;
    push(8'h00); push(8'hFF); push(8'hA5); push(8'h07); push(8'h00); push(8'h07);
    #1;
    wait_valid(20, ok);
    check("zl_seen", ok, 1);
    check("zl_cmd", frame_cmd, 8'h07);
    check("zl_len", frame_len, 8'h00);
    check("zl_drop", drop_cnt, 8'd2);
    tick();
    check("zl_nowrite", wr_n - w0, 0);

    // bad checksum
    e0 = err_cnt; v0 = valid_cnt;
    push(8'hA5); push(8'h01); push(8'h02); push(8'h11); push(8'h22); push(8'h31);
    #1;
    wait_err(20, ok);
    check("cs_err_seen", ok, 1);
    check("cs_code", err_code, 2'd2);
    check("cs_novalid_now", frame_valid, 0);
    tick(); tick();
    check("cs_err_once", err_cnt - e0, 1);
    check("cs_no_valid", valid_cnt - v0, 0);

    // bad length, error right after the LEN pop
    push(8'hA5); push(8'h01); push(8'h11);
    #1;
    tick(); tick(); tick();
    check("len_err", frame_err, 1);
    check("len_code", err_code, 2'd1);
    check("len_novalid", frame_valid, 0);
    w0 = wr_n;
    push(8'hA5); push(8'h03); push(8'h01); push(8'h44); push(8'h46);
    #1;
    wait_valid(20, ok);
    check("len_next_seen", ok, 1);
    check("len_next_cmdlen", {frame_cmd, frame_len}, {8'h03, 8'h01});
    tick();
    check("len_next_wrn", wr_n - w0, 1);
    check("len_next_wr", {wr_addr[w0], wr_data[w0]}, {8'h00, 8'h44});

    // timeout: 7 idle cycles after the last pop
    e0 = err_cnt;
    push(8'hA5); push(8'h01);
    #1;
    tick(); tick();
    repeat (6) tick();
    check("to_not_yet", frame_err, 0);
    tick();
    check("to_err", frame_err, 1);
    check("to_code", err_code, 2'd3);
    tick();
    check("to_err_once", err_cnt - e0, 1);

    // byte arriving on the expiry cycle wins
    e0 = err_cnt;
    push(8'hA5); push(8'h01);
    #1;
    tick(); tick();
    repeat (6) tick();
    push(8'h00);
    #1;
    check("exp_pop", rx_rd, 1);
    tick();
    check("exp_noerr", frame_err, 0);
    push(8'h01);
    #1;
    wait_valid(10, ok);
    check("exp_valid", ok, 1);
    check("exp_cmdlen", {frame_cmd, frame_len}, {8'h01, 8'h00});
    check("exp_code_held", err_code, 2'd3);
    check("exp_no_err", err_cnt - e0, 0);
    tick();

    // backpressure with a second frame queued
    frame_ready = 1'b0;
    push(8'hA5); push(8'h05); push(8'h01); push(8'h77); push(8'h73);
    push(8'hA5); push(8'h06); push(8'h00); push(8'h06);
    #1;
    wait_valid(20, ok);
    check("bp_valid", ok, 1);
    p0 = pop_cnt;
    flag = 1'b1;
    repeat (20) begin
      if (rx_rd !== 1'b0 || frame_valid !== 1'b1 || frame_cmd !== 8'h05) flag = 1'b0;
      tick();
    end
    check("bp_hold", flag, 1);
    check("bp_no_pops", pop_cnt - p0, 0);
    frame_ready = 1'b1;
    #1;
    tick();
    check("bp_released", {frame_valid, rx_rd}, {1'b0, 1'b1});
    wait_valid(20, ok);
    check("bp_second", ok, 1);
    check("bp_second_cmdlen", {frame_cmd, frame_len}, {8'h06, 8'h00});
    tick();

    // enable dropped mid-payload
    e0 = err_cnt; w0 = wr_n;
    push(8'hA5); push(8'h08); push(8'h03); push(8'h10);
    #1;
    tick(); tick(); tick(); tick();
    en = 1'b0;
    p0 = pop_cnt;
    repeat (10) tick();
    push(8'h20); push(8'h30); push(8'h0B);
    #1;
    flag = 1'b1;
    repeat (5) begin
      if (rx_rd !== 1'b0) flag = 1'b0;
      tick();
    end
    check("en_no_rd", flag, 1);
    check("en_no_pops", pop_cnt - p0, 0);
    check("en_no_timeout", err_cnt - e0, 0);
    en = 1'b1;
    #1;
    wait_valid(20, ok);
    check("en_valid", ok, 1);
    check("en_cmdlen", {frame_cmd, frame_len}, {8'h08, 8'h03});
    tick();
    check("en_wrn", wr_n - w0, 3);
    check("en_wr1", {wr_addr[w0+1], wr_data[w0+1]}, {8'h01, 8'h20});
    check("en_wr2", {wr_addr[w0+2], wr_data[w0+2]}, {8'h02, 8'h30});
    check("en_no_err", err_cnt - e0, 0);

    // reset after the LEN pop
    push(8'hA5); push(8'h09); push(8'h04);
    #1;
    tick(); tick(); tick();
    check("rm_pre", {frame_cmd, frame_len}, {8'h09, 8'h04});
    push(8'h01); push(8'h02); push(8'h03); push(8'h04); push(8'h09);
    #1;
    check("rm_pre_rd", rx_rd, 1);
    #1;
    rst = 1'b1;
    #1;
    check("rm_ctrl", {rx_rd, pl_we, frame_valid, frame_err, err_code}, 0);
    check("rm_data", {pl_addr, pl_data, frame_cmd}, 0);
    check("rm_len_drop", {frame_len, drop_cnt}, 0);
    tick();
    rst = 1'b0;
    #1;
    push(8'hA5); push(8'h0A); push(8'h00); push(8'h0A);
    #1;
    wait_valid(30, ok);
    check("rm_valid", ok, 1);
    check("rm_drop", drop_cnt, 8'd5);
    check("rm_cmd", frame_cmd, 8'h0A);
    tick();

    check("err_valid_overlap", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
